// File: rtl/voice_allocator.sv
// Voice allocator: assigns incoming note events to NUM_VOICES synth voices,
// scanning one voice per cycle and stealing the oldest held voice when all are busy.
module voice_allocator #(
   parameter int NUM_VOICES = 8,
   parameter int NOTE_LIMIT = 88,
   parameter int AGE_W      = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      evt_valid,
   output logic                      evt_ready,
   input  logic                      evt_is_on,
   input  logic [6:0]                evt_note,
   input  logic [6:0]                evt_velocity,
   output logic [NUM_VOICES*8-1:0]   voice_note,
   output logic [NUM_VOICES*7-1:0]   voice_velocity,
   output logic [NUM_VOICES-1:0]     voice_gate,
   output logic [NUM_VOICES-1:0]     voice_trigger,
   output logic [AGE_W:0]            active_count,
   output logic                      steal_pulse
);

   // Handshake: an event transfers on a rising clk edge where evt_valid and
   // evt_ready are both high; evt_ready is high only in IDLE and never during reset.

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

   localparam logic [AGE_W-1:0] LAST_IDX = AGE_W'(NUM_VOICES - 1);

   state_t state_r, state_nx;

   logic [NUM_VOICES-1:0][7:0]       note_r, note_nx;
   logic [NUM_VOICES-1:0][6:0]       vel_r, vel_nx;
   logic [NUM_VOICES-1:0][AGE_W-1:0] age_r, age_nx;
   logic [NUM_VOICES-1:0]            gate_r, gate_nx, trig_r, trig_nx;
   logic                             steal_r, steal_nx;
   logic [AGE_W:0]                   count_r, count_nx;

   logic             on_l;
   logic [6:0]       note_l, vel_l;
   logic [AGE_W-1:0] scan_idx, match_idx, free_idx, oldest_idx, oldest_age, target;
   logic             match_found, free_found, oldest_found;
   logic             accept, is_off, note_ok;

   always_ff @(posedge clk) begin
      if (reset) state_r <= IDLE;
      else       state_r <= state_nx;
   end

   always_comb begin
      state_nx  = state_r;
      evt_ready = 1'b0;
      case (state_r)
         IDLE: begin
            evt_ready = ~reset;
            if (evt_valid) state_nx = SCAN;
         end
         SCAN:    if (scan_idx == LAST_IDX) state_nx = COMMIT;
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign accept = evt_valid & evt_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         on_l         <= 1'b0;
         note_l       <= '0;
         vel_l        <= '0;
         scan_idx     <= '0;
         match_found  <= 1'b0;
         free_found   <= 1'b0;
         oldest_found <= 1'b0;
         match_idx    <= '0;
         free_idx     <= '0;
         oldest_idx   <= '0;
         oldest_age   <= '0;
      end else if (accept) begin
         on_l         <= evt_is_on;
         note_l       <= evt_note;
         vel_l        <= evt_velocity;
         scan_idx     <= '0;
         match_found  <= 1'b0;
         free_found   <= 1'b0;
         oldest_found <= 1'b0;
         match_idx    <= '0;
         free_idx     <= '0;
         oldest_idx   <= '0;
         oldest_age   <= '0;
      end else if (state_r == SCAN) begin
         if (gate_r[scan_idx]) begin
            if (!match_found && note_r[scan_idx] == {1'b0, note_l}) begin
               match_found <= 1'b1;
               match_idx   <= scan_idx;
            end
            // Strictly greater keeps the lowest index on an age tie.
            if (!oldest_found || age_r[scan_idx] > oldest_age) begin
               oldest_found <= 1'b1;
               oldest_idx   <= scan_idx;
               oldest_age   <= age_r[scan_idx];
            end
         end else if (!free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
         end
         scan_idx <= scan_idx + 1'b1;
      end
   end

   assign is_off  = ~on_l | (vel_l == 7'd0);
   assign note_ok = (note_l != 7'd0) && (int'(note_l) < NOTE_LIMIT);

   always_comb begin
      note_nx  = note_r;
      vel_nx   = vel_r;
      age_nx   = age_r;
      gate_nx  = gate_r;
      trig_nx  = '0;
      steal_nx = 1'b0;
      target   = match_found ? match_idx : (free_found ? free_idx : oldest_idx);
      if (state_r == COMMIT) begin
         if (is_off) begin
            for (int i = 0; i < NUM_VOICES; i++)
               if (gate_r[i] && note_r[i] == {1'b0, note_l}) gate_nx[i] = 1'b0;
         end else if (note_ok) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (AGE_W'(i) == target) begin
                  note_nx[i] = {1'b0, note_l};
                  vel_nx[i]  = vel_l;
                  gate_nx[i] = 1'b1;
                  age_nx[i]  = '0;
                  trig_nx[i] = 1'b1;
               end else if (gate_r[i] && age_r[i] != LAST_IDX) begin
                  age_nx[i] = age_r[i] + 1'b1;
               end
            end
            steal_nx = ~match_found & ~free_found;
         end
      end
      count_nx = '0;
      for (int i = 0; i < NUM_VOICES; i++)
         count_nx = count_nx + (AGE_W+1)'(gate_nx[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         note_r  <= '0;
         vel_r   <= '0;
         age_r   <= '0;
         gate_r  <= '0;
         trig_r  <= '0;
         steal_r <= 1'b0;
         count_r <= '0;
      end else begin
         note_r  <= note_nx;
         vel_r   <= vel_nx;
         age_r   <= age_nx;
         gate_r  <= gate_nx;
         trig_r  <= trig_nx;
         steal_r <= steal_nx;
         count_r <= count_nx;
      end
   end

   assign voice_note     = note_r;
   assign voice_velocity = vel_r;
   assign voice_gate     = gate_r;
   assign voice_trigger  = trig_r;
   assign active_count   = count_r;
   assign steal_pulse    = steal_r;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation, release, retrigger, stealing,
// reset abort, ignored notes and handshake throughput.
module tb_voice_allocator;

   logic        clk = 1'b0;
   logic        reset;
   logic        evt_valid;
   logic        evt_ready;
   logic        evt_is_on;
   logic [6:0]  evt_note;
   logic [6:0]  evt_velocity;
   logic [63:0] voice_note;
   logic [55:0] voice_velocity;
   logic [7:0]  voice_gate;
   logic [7:0]  voice_trigger;
   logic [3:0]  active_count;
   logic        steal_pulse;

   int n_pass = 0;
   int n_total = 0;

   logic [7:0] trig_at;
   logic       steal_at;
   logic       ready_at;
   logic       ready_early;
   logic       pulse_other;

   voice_allocator dut (
      .clk(clk), .reset(reset), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_is_on(evt_is_on), .evt_note(evt_note), .evt_velocity(evt_velocity),
      .voice_note(voice_note), .voice_velocity(voice_velocity), .voice_gate(voice_gate),
      .voice_trigger(voice_trigger), .active_count(active_count), .steal_pulse(steal_pulse)
   );

   always #5 clk = ~clk;

   task automatic do_reset(input int ncyc);
      @(negedge clk);
      reset = 1'b1;
      evt_valid = 1'b0;
      repeat (ncyc) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Sends one event and observes the 11 cycles after its accept edge.
   task automatic do_event(input logic on, input logic [6:0] note, input logic [6:0] vel);
      int waited;
      @(negedge clk);
      evt_valid = 1'b1; evt_is_on = on; evt_note = note; evt_velocity = vel;
      waited = 0;
      while (!evt_ready && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      n_total++;
      if (!evt_ready) $display("FAIL handshake_timeout: evt_ready=%b required 1", evt_ready);
      else n_pass++;
      @(posedge clk);
      #1 evt_valid = 1'b0;
      trig_at = '0; steal_at = 1'b0; ready_at = 1'b0; ready_early = 1'b0; pulse_other = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (c == 10) begin
            trig_at = voice_trigger; steal_at = steal_pulse; ready_at = evt_ready;
         end else begin
            if (voice_trigger != 8'h00 || steal_pulse) pulse_other = 1'b1;
            if (c < 10 && evt_ready) ready_early = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset = 1'b1; evt_valid = 1'b0; evt_is_on = 1'b0; evt_note = '0; evt_velocity = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_total++;
      if (evt_ready !== 1'b0) $display("FAIL ready_in_reset: got %b required 0", evt_ready);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_total++;
      if (evt_ready !== 1'b1) $display("FAIL ready_after_release: got %b required 1", evt_ready);
      else n_pass++;
      n_total++;
      if ({voice_note, voice_velocity, voice_gate, voice_trigger, active_count, steal_pulse} !== '0)
         $display("FAIL reset_outputs: note=%h vel=%h gate=%h trig=%h cnt=%0d steal=%b required all 0",
                  voice_note, voice_velocity, voice_gate, voice_trigger, active_count, steal_pulse);
      else n_pass++;
   endtask

   task automatic test_allocate;
      do_reset(2);
      do_event(1'b1, 7'd60, 7'd100);
      n_total++;
      if (trig_at !== 8'h01 || steal_at !== 1'b0 || pulse_other !== 1'b0)
         $display("FAIL alloc0_pulse: trig=%h steal=%b other=%b required 01 0 0", trig_at, steal_at, pulse_other);
      else n_pass++;
      n_total++;
      if (ready_at !== 1'b1 || ready_early !== 1'b0)
         $display("FAIL alloc0_latency: ready_at=%b early=%b required 1 0", ready_at, ready_early);
      else n_pass++;
      do_event(1'b1, 7'd64, 7'd90);
      n_total++;
      if (trig_at !== 8'h02 || pulse_other !== 1'b0)
         $display("FAIL alloc1_pulse: trig=%h other=%b required 02 0", trig_at, pulse_other);
      else n_pass++;
      do_event(1'b1, 7'd67, 7'd80);
      n_total++;
      if (trig_at !== 8'h04 || pulse_other !== 1'b0)
         $display("FAIL alloc2_pulse: trig=%h other=%b required 04 0", trig_at, pulse_other);
      else n_pass++;
      n_total++;
      if (voice_note !== 64'h0000_0000_0043_403C)
         $display("FAIL alloc_notes: got %h required 00000000_0043403c", voice_note);
      else n_pass++;
      n_total++;
      if (voice_velocity !== {35'd0, 7'd80, 7'd90, 7'd100})
         $display("FAIL alloc_velocity: got %h required %h", voice_velocity, {35'd0, 7'd80, 7'd90, 7'd100});
      else n_pass++;
      n_total++;
      if (voice_gate !== 8'h07 || active_count !== 4'd3)
         $display("FAIL alloc_gate: gate=%h cnt=%0d required 07 3", voice_gate, active_count);
      else n_pass++;
      n_total++;
      if (dut.age_r !== 24'h00000A)
         $display("FAIL alloc_ages: got %h required 00000a", dut.age_r);
      else n_pass++;
   endtask

   task automatic test_release;
      do_event(1'b0, 7'd64, 7'd0);
      n_total++;
      if (voice_gate !== 8'h05 || voice_note[15:8] !== 8'd64 || active_count !== 4'd2)
         $display("FAIL release_state: gate=%h note1=%0d cnt=%0d required 05 64 2",
                  voice_gate, voice_note[15:8], active_count);
      else n_pass++;
      n_total++;
      if (trig_at !== 8'h00 || steal_at !== 1'b0 || pulse_other !== 1'b0)
         $display("FAIL release_pulse: trig=%h steal=%b other=%b required 00 0 0", trig_at, steal_at, pulse_other);
      else n_pass++;
      do_event(1'b1, 7'd72, 7'd50);
      n_total++;
      if (trig_at !== 8'h02 || voice_note[15:8] !== 8'd72 || voice_gate !== 8'h07 || active_count !== 4'd3)
         $display("FAIL reuse_free: trig=%h note1=%0d gate=%h cnt=%0d required 02 72 07 3",
                  trig_at, voice_note[15:8], voice_gate, active_count);
      else n_pass++;
      n_total++;
      if (dut.age_r !== 24'h000043)
         $display("FAIL reuse_ages: got %h required 000043", dut.age_r);
      else n_pass++;
   endtask

   task automatic test_steal;
      do_reset(2);
      for (int i = 0; i < 8; i++) do_event(1'b1, 7'(40 + i), 7'd64);
      n_total++;
      if (voice_gate !== 8'hFF || active_count !== 4'd8)
         $display("FAIL fill_all: gate=%h cnt=%0d required ff 8", voice_gate, active_count);
      else n_pass++;
      // Retrigger voice 7 so voices 0 and 1 both sit at the saturated age.
      do_event(1'b1, 7'd47, 7'd64);
      n_total++;
      if (trig_at !== 8'h80 || steal_at !== 1'b0)
         $display("FAIL retrig_full: trig=%h steal=%b required 80 0", trig_at, steal_at);
      else n_pass++;
      do_event(1'b1, 7'd50, 7'd9);
      n_total++;
      if (trig_at !== 8'h01 || steal_at !== 1'b1 || pulse_other !== 1'b0)
         $display("FAIL steal_pulse: trig=%h steal=%b other=%b required 01 1 0", trig_at, steal_at, pulse_other);
      else n_pass++;
      n_total++;
      if (voice_note[7:0] !== 8'd50 || voice_velocity[6:0] !== 7'd9 || active_count !== 4'd8)
         $display("FAIL steal_state: note0=%0d vel0=%0d cnt=%0d required 50 9 8",
                  voice_note[7:0], voice_velocity[6:0], active_count);
      else n_pass++;
      do_event(1'b1, 7'd51, 7'd9);
      n_total++;
      if (trig_at !== 8'h02 || steal_at !== 1'b1)
         $display("FAIL steal_next: trig=%h steal=%b required 02 1", trig_at, steal_at);
      else n_pass++;
   endtask

   task automatic test_retrigger;
      do_reset(2);
      do_event(1'b1, 7'd10, 7'd11);
      do_event(1'b1, 7'd20, 7'd22);
      do_event(1'b1, 7'd60, 7'd33);
      do_event(1'b1, 7'd60, 7'd30);
      n_total++;
      if (trig_at !== 8'h04 || steal_at !== 1'b0 || pulse_other !== 1'b0)
         $display("FAIL retrig_pulse: trig=%h steal=%b other=%b required 04 0 0", trig_at, steal_at, pulse_other);
      else n_pass++;
      n_total++;
      if (voice_velocity !== {35'd0, 7'd30, 7'd22, 7'd11} || voice_note !== 64'h0000_0000_003C_140A ||
          voice_gate !== 8'h07)
         $display("FAIL retrig_state: vel=%h note=%h gate=%h required %h 0000000000003c140a 07",
                  voice_velocity, voice_note, voice_gate, {35'd0, 7'd30, 7'd22, 7'd11});
      else n_pass++;
      do_event(1'b1, 7'd60, 7'd0);
      n_total++;
      if (voice_gate !== 8'h03 || active_count !== 4'd2 || trig_at !== 8'h00 || pulse_other !== 1'b0)
         $display("FAIL vel0_off: gate=%h cnt=%0d trig=%h other=%b required 03 2 00 0",
                  voice_gate, active_count, trig_at, pulse_other);
      else n_pass++;
   endtask

   task automatic test_abort_and_ignore;
      int waited;
      logic seen;
      int acc_n, acc0, acc1;
      do_reset(2);
      @(negedge clk);
      evt_valid = 1'b1; evt_is_on = 1'b1; evt_note = 7'd60; evt_velocity = 7'd99;
      waited = 0;
      while (!evt_ready && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      @(posedge clk);
      #1 evt_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (voice_gate != 8'h00 || voice_trigger != 8'h00 || voice_note != 64'h0) seen = 1'b1;
      end
      n_total++;
      if (seen !== 1'b0 || active_count !== 4'd0)
         $display("FAIL abort_scan: change_seen=%b cnt=%0d required 0 0", seen, active_count);
      else n_pass++;

      do_event(1'b1, 7'd60, 7'd40);
      do_event(1'b1, 7'd100, 7'd50);
      n_total++;
      if (trig_at !== 8'h00 || pulse_other !== 1'b0 || voice_gate !== 8'h01 || voice_note[15:0] !== 16'h003C)
         $display("FAIL ignore_high: trig=%h other=%b gate=%h note=%h required 00 0 01 003c",
                  trig_at, pulse_other, voice_gate, voice_note[15:0]);
      else n_pass++;
      do_event(1'b1, 7'd0, 7'd50);
      n_total++;
      if (trig_at !== 8'h00 || pulse_other !== 1'b0 || voice_gate !== 8'h01 || voice_note[15:0] !== 16'h003C)
         $display("FAIL ignore_zero: trig=%h other=%b gate=%h note=%h required 00 0 01 003c",
                  trig_at, pulse_other, voice_gate, voice_note[15:0]);
      else n_pass++;

      @(negedge clk);
      evt_valid = 1'b1; evt_is_on = 1'b0; evt_note = 7'd99; evt_velocity = 7'd0;
      acc_n = 0; acc0 = -1; acc1 = -1;
      for (int c = 0; c < 20; c++) begin
         if (evt_ready) begin
            if (acc_n == 0) acc0 = c;
            else if (acc_n == 1) acc1 = c;
            acc_n++;
         end
         @(negedge clk);
      end
      evt_valid = 1'b0;
      repeat (12) @(negedge clk);
      n_total++;
      if (acc_n !== 2 || acc0 !== 0 || acc1 !== 10)
         $display("FAIL held_valid: accepts=%0d at %0d,%0d required 2 at 0,10", acc_n, acc0, acc1);
      else n_pass++;
      n_total++;
      if (voice_gate !== 8'h01 || active_count !== 4'd1)
         $display("FAIL off_nomatch: gate=%h cnt=%0d required 01 1", voice_gate, active_count);
      else n_pass++;
   endtask

   initial begin
      reset = 1'b1; evt_valid = 1'b0; evt_is_on = 1'b0; evt_note = '0; evt_velocity = '0;
      test_reset();
      test_allocate();
      test_release();
      test_steal();
      test_retrigger();
      test_abort_and_ignore();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
